// File: rtl/ms_path_reverser.sv
// Captures the solver's goal->start back-trace into a LIFO and replays it start->goal over valid/ready.
// Optional macro PATH_CHECK_EN adds a unit-step adjacency check reported on err[2].
module ms_path_reverser #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_not_valid,
  input  logic [3:0]        in_x,
  input  logic [3:0]        in_y,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_fail,
  output logic [3:0]        out_x,
  output logic [3:0]        out_y,
  output logic              out_last,
  output logic [ADDR_W:0]   path_len,
  output logic [2:0]        err,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPLAY, S_FAIL} state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W    = 1;
  localparam logic [ADDR_W-1:0] ONE_A    = 1;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W:0]   r_wp;
  logic [ADDR_W-1:0] r_rp;
  logic [ADDR_W:0]   r_path_len;
  logic [2:0]        r_err;
  logic              w_full;
  logic              w_start;
  logic              w_store;
  logic              w_last;
  logic              w_step_bad;

  assign w_full   = (r_wp == FULL_CNT);
  assign w_last   = (r_rp == '0);
  assign path_len = r_path_len;
  assign err      = r_err;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_store   = 1'b0;
    out_valid = 1'b0;
    out_fail  = 1'b0;
    out_x     = 4'd0;
    out_y     = 4'd0;
    out_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_start = 1'b1;
          w_store = !in_not_valid;
          w_next  = in_not_valid ? S_FAIL : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_valid) w_store = !w_full;
        else          w_next  = S_REPLAY;
      end
      S_REPLAY: begin
        out_valid      = 1'b1;
        {out_x, out_y} = r_mem[r_rp];
        out_last       = w_last;
        if (out_ready && w_last) w_next = S_IDLE;
      end
      S_FAIL: begin
        out_valid = 1'b1;
        out_fail  = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // wp is zero whenever IDLE, so the first coordinate lands in mem[0].
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wp[ADDR_W-1:0]] <= {in_x, in_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_path_len <= '0;
      r_err      <= '0;
    end else begin
      if (w_start) begin
        r_path_len <= '0;
        r_err      <= '0;
      end
      if (w_store) r_wp <= r_wp + ONE_W;
      case (r_state)
        S_COLLECT: begin
          if (in_valid) begin
            if (w_full)     r_err[0] <= 1'b1;
            if (w_step_bad) r_err[2] <= 1'b1;
          end else begin
            r_path_len <= r_wp;
            r_rp       <= r_wp[ADDR_W-1:0] - ONE_A;
          end
        end
        S_REPLAY: begin
          if (in_valid) r_err[1] <= 1'b1;
          if (out_ready) begin
            r_rp <= r_rp - ONE_A;
            if (w_last) r_wp <= '0;
          end
        end
        S_FAIL: begin
          if (in_valid) r_err[1] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PATH_CHECK_EN
  logic [3:0] r_prev_x;
  logic [3:0] r_prev_y;
  logic [4:0] w_dx;
  logic [4:0] w_dy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_x <= '0;
      r_prev_y <= '0;
    end else if (w_store) begin
      r_prev_x <= in_x;
      r_prev_y <= in_y;
    end
  end

  assign w_dx = (in_x >= r_prev_x) ? {1'b0, in_x - r_prev_x} : {1'b0, r_prev_x - in_x};
  assign w_dy = (in_y >= r_prev_y) ? {1'b0, in_y - r_prev_y} : {1'b0, r_prev_y - in_y};
  // Only stored entries are checked; the first entry has no predecessor.
  assign w_step_bad = (r_state == S_COLLECT) && w_store && ((w_dx + w_dy) != 5'd1);
`else
  assign w_step_bad = 1'b0;
`endif

endmodule
